// File: rtl/fix_pkg.sv
// fix_pkg: shared definitions for the FIX transmit-side field serializer.
//   - FIX_SEP / FIX_SOH : the bytes that close a tag ('=') and a value (SOH)
//   - chunk_kind_e      : the kind of an incoming chunk (tag or value)
//   - ser_state_e       : the serializer FSM states
//   - keep_count()      : number of bytes selected by an MSB-first keep mask
//   - keep_contiguous() : true when a keep mask is non-zero and contiguous from bit 3
package fix_pkg;

    localparam logic [7:0] FIX_SEP = 8'h3D;
    localparam logic [7:0] FIX_SOH = 8'h01;

    typedef enum logic {
        KIND_TAG   = 1'b0,
        KIND_VALUE = 1'b1
    } chunk_kind_e;

    typedef enum logic [1:0] {
        ST_EXP_TAG  = 2'd0,
        ST_IN_TAG   = 2'd1,
        ST_IN_VALUE = 2'd2,
        ST_FLUSH    = 2'd3
    } ser_state_e;

    // Only the four legal masks count; any other mask carries no bytes.
    function automatic logic [2:0] keep_count(input logic [3:0] keep);
        case (keep)
            4'b1000: keep_count = 3'd1;
            4'b1100: keep_count = 3'd2;
            4'b1110: keep_count = 3'd3;
            4'b1111: keep_count = 3'd4;
            default: keep_count = 3'd0;
        endcase
    endfunction

    function automatic logic keep_contiguous(input logic [3:0] keep);
        case (keep)
            4'b1000, 4'b1100, 4'b1110, 4'b1111: keep_contiguous = 1'b1;
            default:                            keep_contiguous = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fix_byte_packer.sv
// fix_byte_packer: 8-byte shift buffer, head at [63:56].
//   clk, rst_n   : clock, asynchronous active-low reset
//   push         : append push_n bytes taken MSB-first from push_bytes
//   push_n       : 0..5 bytes to append
//   push_bytes   : up to five bytes, MSB-first; lanes beyond push_n must be 0
//   pop          : remove min(4, count) bytes from the head
//   count        : bytes currently held (0..8)
//   count_next   : count after this cycle's push/pop
//   head_data    : first four bytes of the buffer; empty lanes read as 0
//   head_keep    : MSB-first mask of the valid head lanes
module fix_byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [2:0]  push_n,
    input  logic [39:0] push_bytes,
    input  logic        pop,
    output logic [3:0]  count,
    output logic [3:0]  count_next,
    output logic [31:0] head_data,
    output logic [3:0]  head_keep
);

    logic [63:0] byte_q;
    logic [63:0] byte_next;
    logic [3:0]  count_q;
    logic [2:0]  pop_n;
    logic [3:0]  kept;
    logic [63:0] ins;

    // Bytes beyond count are always zero, so shifting left and OR-ing the
    // new bytes in behind the survivors is enough to keep the buffer dense.
    always_comb begin
        pop_n      = 3'd0;
        if (pop) begin
            pop_n = (count_q >= 4'd4) ? 3'd4 : count_q[2:0];
        end
        kept       = count_q - {1'b0, pop_n};
        ins        = push ? ({push_bytes, 24'h0} >> {kept, 3'b000}) : 64'h0;
        byte_next  = (byte_q << {pop_n, 3'b000}) | ins;
        count_next = kept + (push ? {1'b0, push_n} : 4'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_q  <= 64'h0;
            count_q <= 4'd0;
        end else begin
            byte_q  <= byte_next;
            count_q <= count_next;
        end
    end

    always_comb begin
        case (count_q)
            4'd0:    head_keep = 4'b0000;
            4'd1:    head_keep = 4'b1000;
            4'd2:    head_keep = 4'b1100;
            4'd3:    head_keep = 4'b1110;
            default: head_keep = 4'b1111;
        endcase
    end

    assign head_data = byte_q[63:32];
    assign count     = count_q;

endmodule

// File: rtl/fix_field_serializer.sv
// fix_field_serializer: turns tag/value byte chunks into a dense 32-bit FIX
// byte stream, inserting '=' after each tag and SOH after each value, and
// keeps a mod-256 byte sum per message for the tag-10 checksum generator.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_valid_i / in_ready_o    : chunk handshake (in_ready_o is registered)
//   in_data_i / in_keep_i      : chunk bytes, MSB-first, contiguous keep mask
//   in_kind_i                  : 0 = tag chunk, 1 = value chunk
//   in_last_i / in_eom_i       : last chunk of field / end of message
//   out_valid_o / out_ready_i  : output word handshake
//   out_data_o / out_keep_o    : packed word, MSB-first, unused lanes 0
//   cksum_o / cksum_valid_o    : message byte sum, pulsed once per message
//   err_o                      : sticky protocol error
module fix_field_serializer
    import fix_pkg::*;
#(
    parameter logic [7:0] SEP_CHAR = FIX_SEP,
    parameter logic [7:0] SOH_CHAR = FIX_SOH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_data_i,
    input  logic [3:0]  in_keep_i,
    input  logic        in_kind_i,
    input  logic        in_last_i,
    input  logic        in_eom_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_data_o,
    output logic [3:0]  out_keep_o,
    output logic [7:0]  cksum_o,
    output logic        cksum_valid_o,
    output logic        err_o
);

    ser_state_e  state_q;
    logic [7:0]  acc_q;
    logic        ready_q;
    logic        err_q;
    logic [7:0]  ck_q;
    logic        ckv_q;

    chunk_kind_e kind;
    logic [2:0]  n_data;
    logic        keep_ok;
    logic        kind_ok;
    logic        accept;
    logic        do_push;
    logic        proto_err;
    logic [31:0] data_masked;
    logic [7:0]  term;
    logic [39:0] push_bytes;
    logic [2:0]  push_n;
    logic [7:0]  push_sum;
    logic        out_valid;
    logic        pop;
    logic        flush_done;
    logic        flush_next;

    logic [3:0]  count;
    logic [3:0]  count_next;
    logic [31:0] head_data;
    logic [3:0]  head_keep;

    always_comb begin
        kind        = chunk_kind_e'(in_kind_i);
        n_data      = keep_count(in_keep_i);
        keep_ok     = keep_contiguous(in_keep_i);
        kind_ok     = (state_q == ST_IN_VALUE) ? (kind == KIND_VALUE) : (kind == KIND_TAG);
        accept      = in_valid_i && ready_q;
        // A zero keep on a last chunk still closes the field with its separator.
        do_push     = accept && kind_ok && (keep_ok || ((in_keep_i == 4'b0000) && in_last_i));
        proto_err   = accept && (!kind_ok || !keep_ok);
        data_masked = in_data_i & {{8{in_keep_i[3]}}, {8{in_keep_i[2]}},
                                   {8{in_keep_i[1]}}, {8{in_keep_i[0]}}};
        term        = (kind == KIND_VALUE) ? SOH_CHAR : SEP_CHAR;
        push_bytes  = {data_masked, 8'h00} |
                      (in_last_i ? ({term, 32'h0} >> {n_data, 3'b000}) : 40'h0);
        push_n      = n_data + {2'b00, in_last_i};
        push_sum    = push_bytes[39:32] + push_bytes[31:24] + push_bytes[23:16]
                    + push_bytes[15:8]  + push_bytes[7:0];
        out_valid   = (count >= 4'd4) || ((state_q == ST_FLUSH) && (count != 4'd0));
        pop         = out_valid && out_ready_i;
        flush_done  = pop && (state_q == ST_FLUSH) && (count <= 4'd4);
        flush_next  = ((state_q == ST_FLUSH) && !flush_done) ||
                      (do_push && (state_q == ST_IN_VALUE) && in_last_i && in_eom_i);
    end

    fix_byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (do_push),
        .push_n     (push_n),
        .push_bytes (push_bytes),
        .pop        (pop),
        .count      (count),
        .count_next (count_next),
        .head_data  (head_data),
        .head_keep  (head_keep)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EXP_TAG;
            acc_q   <= 8'h00;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            ck_q    <= 8'h00;
            ckv_q   <= 1'b0;
        end else begin
            // Readiness is registered from the next count so out_ready_i never
            // reaches in_ready_o combinationally.
            ready_q <= (count_next <= 4'd3) && !flush_next;
            ckv_q   <= flush_done;
            if (proto_err) begin
                err_q <= 1'b1;
            end
            if (flush_done) begin
                ck_q    <= acc_q;
                acc_q   <= 8'h00;
                state_q <= ST_EXP_TAG;
            end else if (do_push) begin
                acc_q <= acc_q + push_sum;
                case (state_q)
                    ST_EXP_TAG, ST_IN_TAG: state_q <= in_last_i ? ST_IN_VALUE : ST_IN_TAG;
                    ST_IN_VALUE: begin
                        if (in_last_i) begin
                            state_q <= in_eom_i ? ST_FLUSH : ST_EXP_TAG;
                        end
                    end
                    default: state_q <= state_q;
                endcase
            end
        end
    end

    assign in_ready_o    = ready_q;
    assign out_valid_o   = out_valid;
    assign out_data_o    = out_valid ? head_data : 32'h0;
    assign out_keep_o    = out_valid ? head_keep : 4'h0;
    assign cksum_o       = ck_q;
    assign cksum_valid_o = ckv_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_fix_field_serializer.sv
module tb_fix_field_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_data_i;
    logic [3:0]  in_keep_i;
    logic        in_kind_i;
    logic        in_last_i;
    logic        in_eom_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_data_o;
    logic [3:0]  out_keep_o;
    logic [7:0]  cksum_o;
    logic        cksum_valid_o;
    logic        err_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [35:0] got_w[$];
    logic [7:0]  got_ck[$];

    typedef struct {
        logic [31:0] tdata;
        logic [3:0]  tkeep;
        logic [31:0] vdata;
        logic [3:0]  vkeep;
        logic [35:0] w0;
        logic [35:0] w1;
        logic [7:0]  ck;
    } vec_t;

    vec_t vt[4];

    always #5 clk = ~clk;

    fix_field_serializer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .in_data_i     (in_data_i),
        .in_keep_i     (in_keep_i),
        .in_kind_i     (in_kind_i),
        .in_last_i     (in_last_i),
        .in_eom_i      (in_eom_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_data_o    (out_data_o),
        .out_keep_o    (out_keep_o),
        .cksum_o       (cksum_o),
        .cksum_valid_o (cksum_valid_o),
        .err_o         (err_o)
    );

    // Inputs change 1 time unit after posedge, so at negedge the handshake
    // about to happen on the next posedge is already settled.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid_o && out_ready_i) got_w.push_back({out_data_o, out_keep_o});
            if (cksum_valid_o) got_ck.push_back(cksum_o);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input int idx, input logic [35:0] exp);
        logic [63:0] act;
        act = (idx < got_w.size()) ? {28'h0, got_w[idx]} : 64'hDEAD_0000_0000_0000;
        check(name, act, {28'h0, exp});
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic kind,
                        input logic last, input logic eom);
        logic took;
        took = 1'b0;
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_keep_i  = k;
        in_kind_i  = kind;
        in_last_i  = last;
        in_eom_i   = eom;
        for (int i = 0; i < 60 && !took; i++) begin
            @(negedge clk);
            took = in_ready_o;
            @(posedge clk);
            #1;
        end
        in_valid_i = 1'b0;
        if (!took) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: chunk %0h not accepted, required acceptance", d);
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget && got_ck.size() == 0; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check({name, "_ck_count"}, got_ck.size(), 1);
    endtask

    task automatic clear_q();
        got_w.delete();
        got_ck.delete();
    endtask

    initial begin
        vt[0] = '{32'h33350000, 4'b1100, 32'h44000000, 4'b1000,
                  {32'h33353D44, 4'hF}, {32'h01000000, 4'h8}, 8'hEA};
        vt[1] = '{32'h31000000, 4'b1000, 32'h41424344, 4'b1111,
                  {32'h313D4142, 4'hF}, {32'h43440100, 4'hE}, 8'h79};
        vt[2] = '{32'h35350000, 4'b1100, 32'h78790000, 4'b1100,
                  {32'h35353D78, 4'hF}, {32'h79010000, 4'hC}, 8'h99};
        vt[3] = '{32'h31323300, 4'b1110, 32'h5A000000, 4'b1000,
                  {32'h3132333D, 4'hF}, {32'h5A010000, 4'hC}, 8'h2E};

        rst_n = 1'b0;
        in_valid_i = 1'b0;
        in_data_i = 32'h0;
        in_keep_i = 4'h0;
        in_kind_i = 1'b0;
        in_last_i = 1'b0;
        in_eom_i = 1'b0;
        out_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {out_valid_o, in_ready_o, out_data_o, out_keep_o,
                                cksum_o, cksum_valid_o, err_o}, 64'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-field messages from the table.
        for (int v = 0; v < 4; v++) begin
            clear_q();
            out_ready_i = 1'b1;
            send(vt[v].tdata, vt[v].tkeep, 1'b0, 1'b1, 1'b0);
            send(vt[v].vdata, vt[v].vkeep, 1'b1, 1'b1, 1'b1);
            wait_done($sformatf("vec%0d", v), 50);
            check($sformatf("vec%0d_nwords", v), got_w.size(), 2);
            check_word($sformatf("vec%0d_w0", v), 0, vt[v].w0);
            check_word($sformatf("vec%0d_w1", v), 1, vt[v].w1);
            check($sformatf("vec%0d_ck", v), (got_ck.size() > 0) ? got_ck[0] : 8'h00, vt[v].ck);
            check($sformatf("vec%0d_err", v), err_o, 1'b0);
        end

        // Two-field message with a downstream stall.
        clear_q();
        out_ready_i = 1'b0;
        fork
            begin
                send(32'h38000000, 4'b1000, 1'b0, 1'b1, 1'b0);
                send(32'h46495800, 4'b1110, 1'b1, 1'b1, 1'b0);
                send(32'h39000000, 4'b1000, 1'b0, 1'b1, 1'b0);
                send(32'h31320000, 4'b1100, 1'b1, 1'b1, 1'b1);
            end
            begin
                for (int i = 0; i < 40 && !out_valid_o; i++) @(negedge clk);
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    check($sformatf("stall_c%0d", c),
                          {out_valid_o, in_ready_o, out_data_o, out_keep_o},
                          {1'b1, 1'b0, 32'h383D4649, 4'hF});
                end
                @(posedge clk);
                #1;
                out_ready_i = 1'b1;
            end
        join
        wait_done("stall", 50);
        check("stall_nwords", got_w.size(), 3);
        check_word("stall_w0", 0, {32'h383D4649, 4'hF});
        check_word("stall_w1", 1, {32'h5801393D, 4'hF});
        check_word("stall_w2", 2, {32'h31320100, 4'hE});
        check("stall_ck", (got_ck.size() > 0) ? got_ck[0] : 8'h00, 8'h37);

        // Back-to-back full tag chunks.
        clear_q();
        send(32'h41424344, 4'b1111, 1'b0, 1'b0, 1'b0);
        send(32'h45464748, 4'b1111, 1'b0, 1'b1, 1'b0);
        send(32'h31000000, 4'b1000, 1'b1, 1'b1, 1'b1);
        wait_done("b2b", 50);
        check("b2b_nwords", got_w.size(), 3);
        check_word("b2b_w0", 0, {32'h41424344, 4'hF});
        check_word("b2b_w1", 1, {32'h45464748, 4'hF});
        check_word("b2b_w2", 2, {32'h3D310100, 4'hE});
        check("b2b_ck", (got_ck.size() > 0) ? got_ck[0] : 8'h00, 8'h93);

        // 256 bytes of 0x01: checksum wraps.
        clear_q();
        send(32'h31000000, 4'b1000, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 64; i++) begin
            send(32'h01010101, 4'b1111, 1'b1, i == 63, i == 63);
        end
        wait_done("wrap", 100);
        check("wrap_nwords", got_w.size(), 65);
        check_word("wrap_first", 0, {32'h313D0101, 4'hF});
        check_word("wrap_last", 64, {32'h01010100, 4'hE});
        check("wrap_ck", (got_ck.size() > 0) ? got_ck[0] : 8'h00, 8'h6F);

        // Protocol errors: value chunk in EXP_TAG, then a non-contiguous keep.
        clear_q();
        send(32'h41000000, 4'b1000, 1'b1, 1'b1, 1'b1);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("err_set", err_o, 1'b1);
        check("err_no_output", got_w.size(), 0);
        send(32'h31003300, 4'b1010, 1'b0, 1'b1, 1'b0);
        send(32'h37000000, 4'b1000, 1'b0, 1'b1, 1'b0);
        send(32'h12345678, 4'b0000, 1'b1, 1'b1, 1'b1);
        wait_done("errrec", 50);
        check("errrec_nwords", got_w.size(), 1);
        check_word("errrec_w0", 0, {32'h373D0100, 4'hE});
        check("errrec_ck", (got_ck.size() > 0) ? got_ck[0] : 8'h00, 8'h75);
        check("err_sticky", err_o, 1'b1);

        // Asynchronous reset with 3 bytes buffered in IN_VALUE.
        clear_q();
        send(32'h39000000, 4'b1000, 1'b0, 1'b1, 1'b0);
        send(32'h58000000, 4'b1000, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {out_valid_o, in_ready_o, out_data_o, out_keep_o,
                              cksum_o, cksum_valid_o, err_o}, 64'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_q();
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("post_reset_quiet", got_w.size(), 0);
        send(vt[2].tdata, vt[2].tkeep, 1'b0, 1'b1, 1'b0);
        send(vt[2].vdata, vt[2].vkeep, 1'b1, 1'b1, 1'b1);
        wait_done("postrst", 50);
        check_word("postrst_w0", 0, vt[2].w0);
        check_word("postrst_w1", 1, vt[2].w1);
        check("postrst_ck", (got_ck.size() > 0) ? got_ck[0] : 8'h00, vt[2].ck);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
